// File: rtl/noisy_wave_gen.sv
// noisy_wave_gen: phase-accumulator test-signal source for the filter datapath.
//
// The generator produces square, sawtooth or triangle waves with programmable
// gain. It adds optional LFSR noise to the scaled wave, saturating the result.
// A clock divider sets the sample rate.
//
// Each divider tick launches one sample into a 3-stage pipeline:
//   E0  the tick edge. The phase and the LFSR advance, and the controls are captured.
//   E1  the raw waveform and the noise term are registered.
//   E2  the scaled product is registered.
//   E3  clean_signal and noisy_signal update, and sample_valid is high for one cycle.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset.
//   enable        runs the sample divider.
//   sample_div    sample period minus 1, in clk cycles.
//   phase_inc     phase step per sample.
//   wave_sel      0 square, 1 sawtooth, 2 triangle, 3 zero.
//   amplitude     unsigned gain. 0x8000 is unity, and larger values clamp to 0x8000.
//   noise_en      adds noise when 1.
//   noise_level   arithmetic right shift applied to the noise, 0..15.
//   clean_signal  scaled waveform without noise (signed).
//   noisy_signal  scaled waveform plus noise, saturated (signed).
//   sample_valid  one-cycle strobe when both outputs update.
module noisy_wave_gen #(
  parameter int          PHASE_W   = 24,
  parameter int          DIV_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [DIV_W-1:0]    sample_div,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [1:0]          wave_sel,
  input  logic [15:0]         amplitude,
  input  logic                noise_en,
  input  logic [3:0]          noise_level,
  output logic signed [15:0]  clean_signal,
  output logic signed [15:0]  noisy_signal,
  output logic                sample_valid
);

  // Divider and tick-edge state
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               tick_s;

  // Stage 0: controls captured with the tick
  logic               s0_valid_q;
  logic [1:0]         s0_wave_q, s0_wave_d;
  logic signed [16:0] s0_amp_q, s0_amp_d;
  logic               s0_nen_q, s0_nen_d;
  logic [3:0]         s0_lvl_q, s0_lvl_d;

  // Stage 1: raw waveform and noise term
  logic               s1_valid_q;
  logic signed [15:0] s1_raw_q, s1_raw_d;
  logic signed [16:0] s1_amp_q, s1_amp_d;
  logic signed [15:0] s1_noise_q, s1_noise_d;

  // Stage 2: scaled product
  logic               s2_valid_q;
  logic signed [32:0] s2_prod_q, s2_prod_d;
  logic signed [15:0] s2_noise_q, s2_noise_d;

  // Output stage
  logic signed [15:0] clean_q, clean_d;
  logic signed [15:0] noisy_q, noisy_d;
  logic               valid_q;

  logic [15:0]        p_s;
  logic [14:0]        t_s;
  logic signed [15:0] clean_s;
  logic signed [16:0] sum_s;

  // Divider, phase accumulator and LFSR next state
  always_comb begin
    tick_s    = 1'b0;
    div_cnt_d = div_cnt_q;
    phase_d   = phase_q;
    lfsr_d    = lfsr_q;
    if (!enable) begin
      div_cnt_d = '0;
    end else if (div_cnt_q >= sample_div) begin
      // Using >= rather than == means that lowering sample_div below the count forces a tick.
      tick_s    = 1'b1;
      div_cnt_d = '0;
      phase_d   = phase_q + phase_inc;
      lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Control capture at the tick. The gain is clamped here to 0x8000.
  always_comb begin
    s0_wave_d = s0_wave_q;
    s0_amp_d  = s0_amp_q;
    s0_nen_d  = s0_nen_q;
    s0_lvl_d  = s0_lvl_q;
    if (tick_s) begin
      s0_wave_d = wave_sel;
      s0_nen_d  = noise_en;
      s0_lvl_d  = noise_level;
      if (amplitude > 16'h8000) begin
        s0_amp_d = 17'sh08000;
      end else begin
        s0_amp_d = {1'b0, amplitude};
      end
    end else begin
      s0_wave_d = s0_wave_q;
    end
  end

  // Waveform lookup from the phase top bits, plus the noise term from the advanced LFSR
  always_comb begin
    p_s        = phase_q[PHASE_W-1 -: 16];
    t_s        = p_s[14:0];
    s1_raw_d   = s1_raw_q;
    s1_amp_d   = s1_amp_q;
    s1_noise_d = s1_noise_q;
    if (s0_valid_q) begin
      s1_amp_d = s0_amp_q;
      case (s0_wave_q)
        2'd0: s1_raw_d = p_s[15] ? 16'sh8001 : 16'sh7FFF;
        2'd1: s1_raw_d = {~p_s[15], p_s[14:0]};
        // The rising half is {t,0} - 32768, which flips the top bit of {t,0}.
        2'd2: s1_raw_d = p_s[15] ? (16'sh7FFF - $signed({t_s, 1'b0}))
                                 : $signed({~t_s[14], t_s[13:0], 1'b0});
        default: s1_raw_d = 16'sh0000;
      endcase
      if (s0_nen_q) begin
        s1_noise_d = $signed(lfsr_q) >>> s0_lvl_q;
      end else begin
        s1_noise_d = 16'sh0000;
      end
    end else begin
      s1_raw_d = s1_raw_q;
    end
  end

  // Gain multiply. The clamped gain is non-negative, so a signed 17-bit operand is exact.
  always_comb begin
    s2_prod_d  = s2_prod_q;
    s2_noise_d = s2_noise_q;
    if (s1_valid_q) begin
      s2_prod_d  = s1_raw_q * s1_amp_q;
      s2_noise_d = s1_noise_q;
    end else begin
      s2_prod_d  = s2_prod_q;
    end
  end

  // Rescale the product and add the noise with saturation. The outputs hold between strobes.
  always_comb begin
    // |product| <= 2^30, so bits [30:15] hold the complete shifted result.
    clean_s = s2_prod_q[30:15];
    sum_s   = {clean_s[15], clean_s} + {s2_noise_q[15], s2_noise_q};
    clean_d = clean_q;
    noisy_d = noisy_q;
    if (s2_valid_q) begin
      clean_d = clean_s;
      if (sum_s[16] != sum_s[15]) begin
        noisy_d = sum_s[16] ? 16'sh8000 : 16'sh7FFF;
      end else begin
        noisy_d = sum_s[15:0];
      end
    end else begin
      clean_d = clean_q;
    end
  end

  // State and pipeline registers. Reset discards any samples in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      phase_q    <= '0;
      lfsr_q     <= LFSR_SEED;
      s0_valid_q <= 1'b0;
      s0_wave_q  <= 2'd0;
      s0_amp_q   <= 17'sd0;
      s0_nen_q   <= 1'b0;
      s0_lvl_q   <= 4'd0;
      s1_valid_q <= 1'b0;
      s1_raw_q   <= 16'sd0;
      s1_amp_q   <= 17'sd0;
      s1_noise_q <= 16'sd0;
      s2_valid_q <= 1'b0;
      s2_prod_q  <= 33'sd0;
      s2_noise_q <= 16'sd0;
      clean_q    <= 16'sd0;
      noisy_q    <= 16'sd0;
      valid_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      phase_q    <= phase_d;
      lfsr_q     <= lfsr_d;
      s0_valid_q <= tick_s;
      s0_wave_q  <= s0_wave_d;
      s0_amp_q   <= s0_amp_d;
      s0_nen_q   <= s0_nen_d;
      s0_lvl_q   <= s0_lvl_d;
      s1_valid_q <= s0_valid_q;
      s1_raw_q   <= s1_raw_d;
      s1_amp_q   <= s1_amp_d;
      s1_noise_q <= s1_noise_d;
      s2_valid_q <= s1_valid_q;
      s2_prod_q  <= s2_prod_d;
      s2_noise_q <= s2_noise_d;
      clean_q    <= clean_d;
      noisy_q    <= noisy_d;
      valid_q    <= s2_valid_q;
    end
  end

  assign clean_signal = clean_q;
  assign noisy_signal = noisy_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_noisy_wave_gen.sv
// Testbench for noisy_wave_gen.
//
// A reference model predicts every sample from arithmetic rules. The model
// queues each prediction together with the cycle in which it is due. A
// monitor pops each prediction on sample_valid and compares it with the DUT.
// Directed phases also check known constants.
module tb_noisy_wave_gen;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic [15:0]        sample_div;
  logic [23:0]        phase_inc;
  logic [1:0]         wave_sel;
  logic [15:0]        amplitude;
  logic               noise_en;
  logic [3:0]         noise_level;
  logic signed [15:0] clean_signal;
  logic signed [15:0] noisy_signal;
  logic               sample_valid;

  noisy_wave_gen #(.PHASE_W(24), .DIV_W(16), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_div(sample_div),
    .phase_inc(phase_inc), .wave_sel(wave_sel), .amplitude(amplitude),
    .noise_en(noise_en), .noise_level(noise_level),
    .clean_signal(clean_signal), .noisy_signal(noisy_signal),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int clean;
    int noisy;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_cnt, m_phase, m_lfsr;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model of one tick: apply the arithmetic rules directly and queue the result.
  task automatic model_tick();
    int p, t, raw, a, cl, nz, sum, fb;
    exp_t e;
    m_phase = (m_phase + int'(phase_inc)) % (1 << 24);
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | fb;
    p = m_phase / 256;
    t = p % 32768;
    case (wave_sel)
      2'd0: raw = (p < 32768) ? 32767 : -32767;
      2'd1: raw = p - 32768;
      2'd2: raw = (p < 32768) ? (2 * t - 32768) : (32767 - 2 * t);
      default: raw = 0;
    endcase
    a  = (int'(amplitude) > 32768) ? 32768 : int'(amplitude);
    cl = (raw * a) >>> 15;
    nz = 0;
    if (noise_en) begin
      nz = (m_lfsr >= 32768) ? (m_lfsr - 65536) : m_lfsr;
      nz = nz >>> noise_level;
    end
    sum = cl + nz;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    e.clean = cl;
    e.noisy = sum;
    e.due   = cyc + 3;
    exp_q.push_back(e);
  endtask

  // Model process: resets with the DUT and advances the divider on each rising edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt   = 0;
        m_phase = 0;
        m_lfsr  = 16'hACE1;
        exp_q.delete();
      end else begin
        cyc++;
        if (!enable) begin
          m_cnt = 0;
        end else if (m_cnt >= int'(sample_div)) begin
          m_cnt = 0;
          model_tick();
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Monitor: on each strobe, pop one prediction and compare value and arrival cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency_cycle", cyc, e.due);
          check("clean_sample", int'(clean_signal), e.clean);
          check("noisy_sample", int'(noisy_signal), e.noisy);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_valid_at_cycle", cyc, -1);
      end
    end
  end

  task automatic wait_valid(output int waited);
    waited = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        waited = i;
        break;
      end
    end
    if (waited == 0) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    enable = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    check("drain_queue_size", exp_q.size(), 0);
  endtask

  initial begin
    int w;
    // Reset with random inputs
    rst_n       = 1'b0;
    enable      = 1'($urandom);
    sample_div  = 16'($urandom_range(0, 3));
    phase_inc   = 24'($urandom);
    wave_sel    = 2'($urandom);
    amplitude   = 16'($urandom);
    noise_en    = 1'b1;
    noise_level = 4'($urandom);
    repeat (3) begin
      @(negedge clk);
      check("reset_clean", int'(clean_signal), 0);
      check("reset_noisy", int'(noisy_signal), 0);
      check("reset_valid", int'(sample_valid), 0);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (4) begin
      repeat (5) @(negedge clk);
      check("idle_valid", int'(sample_valid), 0);
      check("idle_noisy", int'(noisy_signal), 0);
    end

    // Square wave at full gain: the first tick occurs in the first enabled cycle
    sample_div = 16'd0; phase_inc = 24'h800000; wave_sel = 2'd0;
    amplitude = 16'h8000; noise_en = 1'b0; noise_level = 4'd0;
    enable = 1'b1;
    wait_valid(w);
    check("square_first_latency", w, 4);
    check("square_s0", int'(clean_signal), -32767);
    @(negedge clk);
    check("square_valid_cont", int'(sample_valid), 1);
    check("square_s1", int'(clean_signal), 32767);
    check("square_s1_noisy", int'(noisy_signal), 32767);
    @(negedge clk);
    check("square_s2", int'(clean_signal), -32767);
    repeat (3) @(negedge clk);
    drain();

    // Divider period of 5, then a lowered sample_div that forces an early tick
    wave_sel = 2'd1; phase_inc = 24'($urandom); sample_div = 16'd4;
    enable = 1'b1;
    wait_valid(w);
    wait_valid(w);
    check("div4_period", w, 5);
    wait_valid(w);
    check("div4_period2", w, 5);
    sample_div = 16'd1;
    wait_valid(w);
    check("div_lowered_first", w, 4);
    wait_valid(w);
    check("div1_period", w, 2);
    wait_valid(w);
    check("div1_period2", w, 2);
    drain();

    // Sawtooth at half gain from phase 0, then a gain above 0x8000
    reset_dut();
    sample_div = 16'd0; phase_inc = 24'h400000; wave_sel = 2'd1;
    amplitude = 16'h4000; noise_en = 1'b0;
    enable = 1'b1;
    wait_valid(w);
    check("saw_s0", int'(clean_signal), -8192);
    @(negedge clk); check("saw_s1", int'(clean_signal), 0);
    @(negedge clk); check("saw_s2", int'(clean_signal), 8192);
    @(negedge clk); check("saw_s3", int'(clean_signal), -16384);
    amplitude = 16'hFFFF;
    repeat (8) @(negedge clk);
    drain();

    // Noise on a zero wave: the first LFSR step yields 0x59C3
    reset_dut();
    wave_sel = 2'd3; noise_en = 1'b1; noise_level = 4'd0; amplitude = 16'h8000;
    enable = 1'b1;
    wait_valid(w);
    check("noise_first", int'(noisy_signal), 22979);
    check("noise_first_clean", int'(clean_signal), 0);
    drain();

    // Square plus positive noise saturates at the top
    reset_dut();
    wave_sel = 2'd0; phase_inc = 24'd0; noise_en = 1'b1; noise_level = 4'd0;
    enable = 1'b1;
    wait_valid(w);
    check("sat_noisy", int'(noisy_signal), 32767);
    check("sat_clean", int'(clean_signal), 32767);
    noise_level = 4'd15; wave_sel = 2'd3;
    repeat (6) @(negedge clk);
    check("lvl15_range", int'(noisy_signal == 16'sd0 || noisy_signal == -16'sd1), 1);
    drain();

    // Mid-stream reset with three samples in flight
    sample_div = 16'd0; wave_sel = 2'd2; phase_inc = 24'($urandom); enable = 1'b1;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_valid", int'(sample_valid), 0);
      check("midrst_clean", int'(clean_signal), 0);
      check("midrst_noisy", int'(noisy_signal), 0);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(negedge clk);
    wave_sel = 2'd3; noise_en = 1'b1; noise_level = 4'd0; enable = 1'b1;
    wait_valid(w);
    check("midrst_noise_restart", int'(noisy_signal), 22979);

    // Random traffic, with control changes while samples are in flight
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) sample_div  = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) wave_sel    = 2'($urandom);
      if ($urandom_range(0, 3) == 0) amplitude   = 16'($urandom);
      if ($urandom_range(0, 3) == 0) noise_en    = 1'($urandom);
      if ($urandom_range(0, 3) == 0) noise_level = 4'($urandom);
      if ($urandom_range(0, 7) == 0) phase_inc   = 24'($urandom);
      if ($urandom_range(0, 19) == 0) enable     = ~enable;
    end
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noisy_wave_gen.md
# noisy_wave_gen

Test-signal source for the filter datapath: a phase-accumulator waveform generator (square / sawtooth / triangle) with programmable amplitude and LFSR-based additive noise. It produces the signed 16-bit `noisy_signal` sample stream that the FIR filter consumes, plus the noise-free `clean_signal` as a reference for checking the filter output. Sample rate is set by a clock divider, and every new sample is marked with a one-cycle `sample_valid` strobe.

## Interface
- `PHASE_W`, 24: phase accumulator width (≥16)
- `DIV_W`, 16: sample divider width
- `LFSR_SEED`, 16'hACE1: LFSR reset value (must be non-zero)

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: run the sample divider.
- `sample_div` in DIV_W: sample period minus 1, in clk cycles.
- `phase_inc` in PHASE_W: phase step per sample.
- `wave_sel` in 2: 0 square, 1 sawtooth, 2 triangle, 3 zero.
- `amplitude` in 16: unsigned gain; 0x8000 = unity; values > 0x8000 are clamped to 0x8000.
- `noise_en` in 1: add noise when 1.
- `noise_level` in 4: noise attenuation, arithmetic right shift 0..15.
- `clean_signal` out 16 signed: scaled waveform without noise.
- `noisy_signal` out 16 signed: scaled waveform plus noise, saturated.
- `sample_valid` out 1: one-cycle strobe when both outputs update.

## Operation
- **Divider**
  - `div_cnt` is held at 0 while `enable`=0.
  - A tick occurs when `enable`=1 and `div_cnt >= sample_div`; `div_cnt` then goes to 0. Otherwise `div_cnt` increments.
  - `sample_div`=0 gives a tick every cycle. Lowering `sample_div` below the current count forces a tick on the next cycle.
- **Tick edge (E0)**
  - `phase <= phase + phase_inc`, wrapping modulo 2^PHASE_W.
  - LFSR steps once. It steps on every tick regardless of `noise_en`.
  - `wave_sel`, `amplitude`, `noise_en` and `noise_level` are captured into the pipeline with the tick. Changing them later does not affect in-flight samples.
- **LFSR**: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Next value = {q[14:0], q[15]^q[13]^q[12]^q[10]}.
- **Waveform**: p = phase[PHASE_W-1:PHASE_W-16], t = p[14:0].
  - Square: +32767 if p[15]=0, else −32767.
  - Sawtooth: p − 32768, as signed.
  - Triangle: if p[15]=0, {t,0} − 32768; else 32767 − {t,0}.
  - Zero: 0.
- **Scaling**: raw (16-bit signed) × amp (17-bit, clamped) gives a signed product; `clean` = product >>> 15, exact in 16 bits.
- **Noise**: n = signed(lfsr) >>> noise_level when `noise_en`=1, else 0.
- **Sum**: `noisy` = `clean` + n computed at 17 bits, saturated to [−32768, 32767].
- **Reset**
  - `phase`, `div_cnt`, all pipeline registers and all outputs go to 0.
  - LFSR goes to LFSR_SEED.
  - Reset asserted mid-operation discards in-flight samples immediately; no `sample_valid` is produced for them.
- **Disable**: deasserting `enable` stops new ticks. Samples already in the pipeline still complete and emit their `sample_valid`.

## Timing
- **Pipeline**
  - E0: tick edge; `phase` and LFSR update.
  - E1: raw waveform and noise term registered.
  - E2: scaled product registered.
  - E3: `clean_signal` and `noisy_signal` update and `sample_valid` rises.
- **Latency**: `sample_valid` is high for exactly the one cycle after E3, i.e. 3 edges after the tick edge.
- **Throughput**: one sample per (`sample_div`+1) cycles; with `sample_div`=0, `sample_valid` is high continuously.
- **Hold**: outputs keep their last values between strobes.
- **Enable start**: after `enable` rises from a held state, the first tick occurs `sample_div` cycles later (at `sample_div`=0, in the first enabled cycle).
- **Reset values**: all outputs 0 during and immediately after reset.

## Test plan
- **Reset**: `rst_n`=0 with random inputs → `clean_signal`=`noisy_signal`=0, `sample_valid`=0. After release with `enable`=0 they stay 0 indefinitely.
- **Square wave**
  - Stimulus: square, `phase_inc`=2^23, `amplitude`=0x8000, `noise_en`=0, `sample_div`=0, `enable`=1.
  - Response: `sample_valid` high every cycle, starting 3 edges after the first tick. `clean_signal` = `noisy_signal` = −32767, +32767, −32767, ...
- **Divider**: `sample_div`=4 → `sample_valid` pulses exactly every 5 cycles. Changing `sample_div` to 1 while `div_cnt`=3 → tick on the next cycle, then a 2-cycle period.
- **Sawtooth with half gain**: sawtooth, `phase_inc`=2^22, `amplitude`=0x4000 → `clean_signal` = −8192, 0, 8192, −16384, repeating. `amplitude`=0xFFFF gives the same samples as 0x8000.
- **Noise and saturation**
  - Zero wave, `noise_en`=1, `noise_level`=0 → first `noisy_signal` = 0x59C3 (22979), `clean_signal`=0.
  - Square with `phase_inc`=0, unity gain, same noise → `noisy_signal` clipped to 32767, `clean_signal`=32767.
  - `noise_level`=15 → noise ∈ {0, −1}.
- **Reset mid-stream**: pull `rst_n` low with 3 samples in flight → outputs 0 immediately and no strobes. After release and re-enable, the first noisy zero-wave sample is 0x59C3 again.
